operand_bank_seq: RTL and testbench

OPERAND_BANK_SEQ -- requirements
Module: operand_bank_seq

---
 rtl/operand_bank_seq.sv | 139 +++++++++++++
 tb/tb_operand_bank_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/operand_bank_seq.sv
// operand_bank_seq: four-entry operand bank feeding a registered 4-way mux,
// plus a small sequencer that sweeps the mux select 00..11 PASSES times per
// start. Every output comes straight from a flop; no input reaches an output
// combinationally.
//
// Handshake: start and abort are level-sampled requests with no ready/ack.
// start is accepted only in IDLE; abort is honoured only in SCAN. wr_en is
// accepted only in IDLE (busy=0); writes while busy are silently dropped.
module operand_bank_seq #(
  parameter int PASSES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [0:1]  wr_addr,
  input  logic [0:15] wr_data,
  input  logic        start,
  input  logic        abort,
  output logic [0:15] out_A,
  output logic [0:15] out_B,
  output logic [0:15] out_C,
  output logic [0:15] out_D,
  output logic [0:1]  select,
  output logic        sel_valid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Pass index of the final sweep; the sweep ends when select=11 on this pass.
  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

  state_e      state_q, state_d;
  logic [1:0]  select_q, select_d;
  logic [7:0]  pass_q, pass_d;
  logic        sel_valid_q, sel_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bank_q [4];
  logic [15:0] bank_d [4];

  // Next-state, next-output and bank-write logic.
  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    pass_d      = pass_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bank_d      = bank_q;
    case (state_q)
      IDLE: begin
        select_d    = 2'b00;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        // Write and start may coincide; the write lands on the same edge
        // that enters SCAN, so it is visible in the first sel_valid cycle.
        if (wr_en) bank_d[wr_addr] = wr_data;
        if (start) begin
          state_d     = SCAN;
          select_d    = 2'b00;
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          pass_d      = 8'd0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d     = IDLE;
          select_d    = 2'b00;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          pass_d      = 8'd0;
        end else if (select_q == 2'b11 && pass_q == LAST_PASS) begin
          state_d     = DONE;
          select_d    = 2'b00;
          sel_valid_d = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b1;
        end else begin
          select_d = select_q + 2'd1;
          if (select_q == 2'b11) pass_d = pass_q + 8'd1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        select_d    = 2'b00;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        pass_d      = 8'd0;
      end
      default: begin
        state_d     = IDLE;
        select_d    = 2'b00;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        pass_d      = 8'd0;
      end
    endcase
  end

  // State, output and bank registers with synchronous reset (reset wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      select_q    <= 2'b00;
      pass_q      <= 8'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 4; i++) bank_q[i] <= 16'h0000;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      pass_q      <= pass_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < 4; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign out_A     = bank_q[0];
  assign out_B     = bank_q[1];
  assign out_C     = bank_q[2];
  assign out_D     = bank_q[3];
  assign select    = select_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_bank_seq.sv
// Testbench for operand_bank_seq: two instances (PASSES=1 and PASSES=3) share
// one set of inputs; a queue-based reference model predicts every cycle.
module tb_operand_bank_seq;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, start, abort;
  logic [0:1]  wr_addr;
  logic [0:15] wr_data;

  logic [15:0] oa [2];
  logic [15:0] ob [2];
  logic [15:0] oc [2];
  logic [15:0] od [2];
  logic [1:0]  sel_o [2];
  logic [1:0]  st_o [2];
  logic        sv_o [2];
  logic        busy_o [2];
  logic        done_o [2];

  operand_bank_seq #(.PASSES(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort),
    .out_A(oa[0]), .out_B(ob[0]), .out_C(oc[0]), .out_D(od[0]),
    .select(sel_o[0]), .sel_valid(sv_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .dbg_state(st_o[0])
  );

  operand_bank_seq #(.PASSES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort),
    .out_A(oa[1]), .out_B(ob[1]), .out_C(oc[1]), .out_D(od[1]),
    .select(sel_o[1]), .sel_valid(sv_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .dbg_state(st_o[1])
  );

  int checks = 0;
  int errors = 0;
  int done_seen [2];

  // Scoreboard: per instance, a queue of the cycle-by-cycle outputs still to
  // come for the current sweep. Entry = {select[1:0], sel_valid, busy, done}.
  logic [4:0]  exp_q [2][$];
  logic [4:0]  cur [2];
  logic [15:0] bank [2][4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: advance one clock edge using the inputs now applied.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? 1 : 3;
      if (rst) begin
        exp_q[k].delete();
        cur[k] = 5'b0;
        for (int i = 0; i < 4; i++) bank[k][i] = 16'h0000;
      end else if (cur[k][2] && abort) begin
        exp_q[k].delete();
        cur[k] = 5'b0;
      end else begin
        if (!cur[k][1]) begin
          if (wr_en) bank[k][wr_addr] = wr_data;
          if (start) begin
            for (int i = 0; i < 4 * p; i++) exp_q[k].push_back({2'(i % 4), 3'b110});
            exp_q[k].push_back(5'b00011);
          end
        end
        cur[k] = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 5'b0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [1:0] exp_st;
      exp_st = !cur[k][1] ? 2'd0 : (cur[k][0] ? 2'd2 : 2'd1);
      check($sformatf("ctl%0d", k),
            64'({sel_o[k], sv_o[k], busy_o[k], done_o[k]}), 64'(cur[k]));
      check($sformatf("bank%0d", k), {oa[k], ob[k], oc[k], od[k]},
            {bank[k][0], bank[k][1], bank[k][2], bank[k][3]});
      check($sformatf("state%0d", k), 64'(st_o[k]), 64'(exp_st));
      if (done_o[k]) done_seen[k]++;
    end
  endtask

  // Driver: apply inputs, take one edge, update the model, check mid-cycle.
  task automatic drive(input logic r, input logic we, input logic [1:0] a,
                       input logic [15:0] d, input logic s, input logic ab);
    rst = r; wr_en = we; wr_addr = a; wr_data = d; start = s; abort = ab;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    done_seen[0] = 0;
    done_seen[1] = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd1, 16'h5555, 1'b1, 1'b0);  // reset beats write/start
    // Load bank and run a full sweep on both instances
    drive(1'b0, 1'b1, 2'd0, 16'h1111, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 16'h2222, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd2, 16'h3333, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 16'h4444, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);     // start while busy: ignored
    idle(14);
    check("done_count_p1", 64'(done_seen[0]), 64'd1);
    check("done_count_p3", 64'(done_seen[1]), 64'd1);
    // Write while busy is dropped; the same write in IDLE lands
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 16'hABCD, 1'b0, 1'b0);
    idle(14);
    drive(1'b0, 1'b1, 2'd1, 16'hABCD, 1'b0, 1'b0);
    // Abort while select=10, then restart
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    idle(2);
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    idle(14);
    // Abort in IDLE does nothing
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    // Reset while select=01
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    idle(2);
    // Write D and start in the same cycle
    drive(1'b0, 1'b1, 2'd3, 16'hBEEF, 1'b1, 1'b0);
    check("beef_first_valid", {48'h0, od[0]}, 64'hBEEF);
    idle(14);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)),
            16'($urandom),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 11) == 0);
    end
    idle(16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
